// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
// The optional ICACHE_PERF_EN build adds hit/miss counters in the top module.
package icache_pkg;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;
  localparam int OFFS_W = 2;
  localparam int MEM_ADDR_W = ADDR_W - OFFS_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;
endpackage

// File: rtl/icache_line_store.sv
// Line storage for the cache: per-line valid, tag and 128-bit data.
// Has one write port and one combinational read port; async reset clears only the valid bits.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = $clog2(NUM_LINES),
  parameter int TAG_W     = MEM_ADDR_W - INDEX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [INDEX_W-1:0] i_widx,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [INDEX_W-1:0] i_ridx,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_data
);
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only ever read through its valid bit.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];
endmodule

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache: IDLE/FETCH refill FSM, hit compare and word mux.
// Define ICACHE_PERF_EN to add the saturating hit_cnt/miss_cnt output counters.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_read,
  input  logic [ADDR_W-1:0]     proc_addr,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = MEM_ADDR_W - INDEX_W;

  state_e                r_state;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0]     r_rdata;

  logic [OFFS_W-1:0]  w_offset;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_valid;
  logic [TAG_W-1:0]   w_line_tag;
  logic [LINE_W-1:0]  w_line_data;
  logic [WORD_W-1:0]  w_word;
  logic               w_idle;
  logic               w_hit;
  logic               w_miss;
  logic               w_refill;

  assign w_offset = proc_addr[OFFS_W-1:0];
  assign w_index  = proc_addr[OFFS_W +: INDEX_W];
  assign w_tag    = proc_addr[ADDR_W-1 -: TAG_W];

  assign w_idle   = (r_state == IDLE);
  assign w_hit    = w_idle && proc_read && w_valid && (w_line_tag == w_tag);
  assign w_miss   = w_idle && proc_read && !w_hit;
  // Refill targets the latched line address, so a mid-stall proc_addr change cannot redirect it.
  assign w_refill = (r_state == FETCH) && mem_ready;
  assign w_word   = w_line_data[{w_offset, 5'd0} +: WORD_W];

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_refill),
    .i_widx  (r_mem_addr[INDEX_W-1:0]),
    .i_wtag  (r_mem_addr[MEM_ADDR_W-1 -: TAG_W]),
    .i_wdata (mem_rdata),
    .i_ridx  (w_index),
    .o_valid (w_valid),
    .o_tag   (w_line_tag),
    .o_data  (w_line_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mem_addr <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) r_rdata <= w_word;
          if (w_miss) begin
            r_mem_addr <= {w_tag, w_index};
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Hits return data in the same cycle; otherwise the last delivered word is held.
  assign proc_rdata = w_hit ? w_word : r_rdata;
  assign proc_stall = w_miss || (r_state == FETCH);
  assign mem_read   = (r_state == FETCH);
  assign mem_addr   = r_mem_addr;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: cold miss, hits, conflict, handshake, reset mid-refill.
// Counter checks are included when ICACHE_PERF_EN is defined.
module tb_icache_direct_mapped;
  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_A = {32'hD, 32'hC, 32'hB, 32'hA};
  localparam logic [127:0] LINE_X = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
  localparam logic [127:0] LINE_J = {32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D};
  localparam logic [127:0] LINE_5 = {32'h77, 32'h66, 32'h55, 32'h44};

  icache_direct_mapped #(.NUM_LINES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_addr  (proc_addr),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Serve an outstanding refill: the current cycle is the miss cycle. Holds mem_ready
  // low for (lat-1) FETCH cycles, pulses it on the lat-th, then steps into the next IDLE cycle.
  task automatic serve_refill(input string tag, input logic [27:0] exp_addr,
                              input int lat, input logic [127:0] line);
    for (int i = 1; i <= lat; i++) begin
      next_cycle();
      mem_ready = (i == lat);
      mem_rdata = (i == lat) ? line : 128'h0;
      settle();
      check({tag, "_mem_read"}, 128'(mem_read), 128'(1'b1));
      check({tag, "_mem_addr"}, 128'(mem_addr), 128'(exp_addr));
      check({tag, "_stall_fetch"}, 128'(proc_stall), 128'(1'b1));
    end
    next_cycle();
    mem_ready = 1'b0;
    mem_rdata = '0;
    settle();
    check({tag, "_mem_read_drop"}, 128'(mem_read), 128'(1'b0));
  endtask

  initial begin
    rst_n     = 1'b0;
    proc_read = 1'b0;
    proc_addr = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    #12;
    check("rst_stall", 128'(proc_stall), 128'(1'b0));
    check("rst_mem_read", 128'(mem_read), 128'(1'b0));
    check("rst_rdata", 128'(proc_rdata), 128'(32'h0));
    check("rst_mem_write", 128'(mem_write), 128'(1'b0));
    check("rst_mem_wdata", mem_wdata, 128'h0);
`ifdef ICACHE_PERF_EN
    check("rst_hit_cnt", 128'(hit_cnt), 128'(32'd0));
    check("rst_miss_cnt", 128'(miss_cnt), 128'(32'd0));
`endif
    rst_n = 1'b1;

    // Cold miss on word address 4 (index 1, tag 0), memory latency 5
    next_cycle();
    proc_read = 1'b1;
    proc_addr = 30'h4;
    settle();
    check("cold_stall", 128'(proc_stall), 128'(1'b1));
    check("cold_no_req_yet", 128'(mem_read), 128'(1'b0));
    serve_refill("cold", 28'h1, 5, LINE_A);
    check("cold_rdata", 128'(proc_rdata), 128'(32'hA));
    check("cold_stall_clear", 128'(proc_stall), 128'(1'b0));

    // Hits on the rest of the line
    for (int w = 1; w < 4; w++) begin
      next_cycle();
      proc_addr = 30'(4 + w);
      settle();
      check("hit_rdata", 128'(proc_rdata), 128'(32'hA + w));
      check("hit_stall", 128'(proc_stall), 128'(1'b0));
      check("hit_mem_read", 128'(mem_read), 128'(1'b0));
    end

    // Idle: data holds, no request
    next_cycle();
    proc_read = 1'b0;
    settle();
    check("idle_hold_rdata", 128'(proc_rdata), 128'(32'hD));
    check("idle_stall", 128'(proc_stall), 128'(1'b0));
`ifdef ICACHE_PERF_EN
    check("perf_hit_cnt", 128'(hit_cnt), 128'(32'd4));
    check("perf_miss_cnt", 128'(miss_cnt), 128'(32'd1));
`endif

    // Stray mem_ready in IDLE must not write the last refilled line
    next_cycle();
    mem_ready = 1'b1;
    mem_rdata = LINE_J;
    settle();
    check("stray_mem_read", 128'(mem_read), 128'(1'b0));
    next_cycle();
    mem_ready = 1'b0;
    mem_rdata = '0;
    proc_read = 1'b1;
    proc_addr = 30'h4;
    settle();
    check("stray_no_write_rdata", 128'(proc_rdata), 128'(32'hA));
    check("stray_no_write_stall", 128'(proc_stall), 128'(1'b0));
    next_cycle();
    settle();
    check("stray_no_second_req", 128'(mem_read), 128'(1'b0));

    // Conflict: 0x24 maps to index 1 with tag 1
    proc_addr = 30'h24;
    settle();
    check("conf_stall", 128'(proc_stall), 128'(1'b1));
    serve_refill("conf", 28'h9, 2, LINE_X);
    check("conf_rdata", 128'(proc_rdata), 128'(32'h1000));
    next_cycle();
    proc_addr = 30'h27;
    settle();
    check("conf_hit_w3", 128'(proc_rdata), 128'(32'h1003));

    // Revisiting 0x4 misses again, memory latency 1
    next_cycle();
    proc_addr = 30'h4;
    settle();
    check("revisit_stall", 128'(proc_stall), 128'(1'b1));
    serve_refill("revisit", 28'h1, 1, LINE_A);
    check("revisit_rdata", 128'(proc_rdata), 128'(32'hA));

    // Reset two cycles into a refill of 0x10 (index 4)
    next_cycle();
    proc_addr = 30'h10;
    settle();
    check("midrst_miss", 128'(proc_stall), 128'(1'b1));
    next_cycle();
    settle();
    check("midrst_fetch1", 128'(mem_read), 128'(1'b1));
    next_cycle();
    settle();
    check("midrst_fetch2", 128'(mem_read), 128'(1'b1));
    proc_read = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = LINE_J;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_read_async", 128'(mem_read), 128'(1'b0));
    check("midrst_stall", 128'(proc_stall), 128'(1'b0));
    next_cycle();
    mem_ready = 1'b0;
    mem_rdata = '0;
    rst_n = 1'b1;

    // All lines invalid after reset: 0x5 and 0x10 both miss
    next_cycle();
    proc_read = 1'b1;
    proc_addr = 30'h5;
    settle();
    check("postrst_5_miss", 128'(proc_stall), 128'(1'b1));
    serve_refill("postrst", 28'h1, 3, LINE_5);
    check("postrst_5_rdata", 128'(proc_rdata), 128'(32'h55));
    next_cycle();
    proc_addr = 30'h10;
    settle();
    check("postrst_10_miss", 128'(proc_stall), 128'(1'b1));
    serve_refill("postrst10", 28'h4, 1, LINE_X);
    check("postrst_10_rdata", 128'(proc_rdata), 128'(32'h1000));
`ifdef ICACHE_PERF_EN
    next_cycle();
    proc_read = 1'b0;
    settle();
    check("perf_after_rst_hit", 128'(hit_cnt), 128'(32'd2));
    check("perf_after_rst_miss", 128'(miss_cnt), 128'(32'd2));
`endif

    next_cycle();
    proc_read = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
